eth_rx_framer: RTL and testbench



---
 rtl/eth_rx_pkg.sv | 30 +++
 rtl/eth_rx_framer_crc32.sv | 38 +++
 rtl/eth_rx_framer.sv | 228 ++++++++++++++++++++++
 tb/tb_eth_rx_framer.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_rx_pkg.sv
// eth_rx_pkg: shared types, constants and the CRC32 byte-update helper
// for the Ethernet receive framer.
package eth_rx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PREAMBLE = 2'd1,
    ST_DATA     = 2'd2,
    ST_DROP     = 2'd3
  } rx_state_e;

  localparam logic [7:0]  ETH_PREAMBLE = 8'h55;
  localparam logic [7:0]  ETH_SFD      = 8'hD5;
  localparam logic [31:0] CRC_INIT     = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_RESIDUE  = 32'hDEBB_20E3;
  localparam logic [31:0] CRC_POLY     = 32'hEDB8_8320;
  localparam int unsigned ETH_MIN_LEN  = 64;

  // Reflected CRC32 update by one byte, LSB first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc,
                                             input logic [7:0]  data);
    logic [31:0] c;
    c = crc ^ {24'h0, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/eth_rx_framer_crc32.sv
// eth_crc32: byte-wide CRC32 accumulator.
// Ports: clk_i/rst_i (sync, active-high), clr_i reloads the initial value,
// en_i folds data_i into the register, crc_o is the registered CRC.
module eth_crc32
  import eth_rx_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clr_i,
  input  logic        en_i,
  input  logic [7:0]  data_i,
  output logic [31:0] crc_o
);

  logic [31:0] crc_q;
  logic [31:0] crc_d;

  // Clear wins over update so a frame start always begins from the seed.
  always_comb begin
    crc_d = crc_q;
    if (clr_i) begin
      crc_d = CRC_INIT;
    end else if (en_i) begin
      crc_d = crc32_byte(crc_q, data_i);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      crc_q <= CRC_INIT;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/eth_rx_framer.sv
// eth_rx_framer: GMII receive framer. Strips preamble/SFD, packs frame bytes
// little-endian into 64-bit buffer words, checks the FCS and reports a
// per-frame status over a valid/ready port.
// Ports:
//   clk_i, rst_i               - byte clock, sync active-high reset
//   rx_dv_i, rx_er_i, rxd_i    - GMII receive byte stream
//   mem_we_o/addr/wdata/be     - RX buffer write port (one strobe per word)
//   stat_valid_o, stat_ready_i - frame status handshake
//   stat_len/fcs_ok/err/runt   - status fields, stable while valid
//   drop_cnt_o                 - saturating count of frames lost to a pending status
//   busy_o                     - FSM not idle
module eth_rx_framer
  import eth_rx_pkg::*;
#(
  parameter int unsigned DW     = 64,
  parameter int unsigned BUF_AW = 8,
  parameter int unsigned LW     = 16
)
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              rx_dv_i,
  input  logic              rx_er_i,
  input  logic [7:0]        rxd_i,
  output logic              mem_we_o,
  output logic [BUF_AW-1:0] mem_addr_o,
  output logic [DW-1:0]     mem_wdata_o,
  output logic [7:0]        mem_be_o,
  output logic              stat_valid_o,
  input  logic              stat_ready_i,
  output logic [LW-1:0]     stat_len_o,
  output logic              stat_fcs_ok_o,
  output logic              stat_err_o,
  output logic              stat_runt_o,
  output logic [LW-1:0]     drop_cnt_o,
  output logic              busy_o
);

  localparam int unsigned CAP = 2 ** (BUF_AW + 3);

  rx_state_e         state_q, state_d;
  logic [LW-1:0]     cnt_q, cnt_d;
  logic              err_q, err_d;
  logic [DW-1:0]     asm_q, asm_d;
  logic              dv_prev_q;
  logic              mem_we_q, mem_we_d;
  logic [BUF_AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0]     mem_wdata_q, mem_wdata_d;
  logic [7:0]        mem_be_q, mem_be_d;
  logic              stat_valid_q, stat_valid_d;
  logic [LW-1:0]     stat_len_q, stat_len_d;
  logic              stat_fcs_ok_q, stat_fcs_ok_d;
  logic              stat_err_q, stat_err_d;
  logic              stat_runt_q, stat_runt_d;
  logic [LW-1:0]     drop_cnt_q, drop_cnt_d;
  logic              busy_q, busy_d;

  logic              crc_clr_c, crc_en_c;
  logic [31:0]       crc_val;
  logic [2:0]        lane;
  logic              ovf;
  logic              sfd_seen;

  assign lane     = cnt_q[2:0];
  // Once the count reaches buffer capacity further bytes cannot be stored.
  assign ovf      = {1'b0, cnt_q} >= (LW + 1)'(CAP);
  assign sfd_seen = (state_q == ST_PREAMBLE) && rx_dv_i && (rxd_i == ETH_SFD);

  eth_crc32 u_crc (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clr_i  (crc_clr_c),
    .en_i   (crc_en_c),
    .data_i (rxd_i),
    .crc_o  (crc_val)
  );

  // State register plus all datapath flops.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      err_q         <= 1'b0;
      asm_q         <= '0;
      dv_prev_q     <= 1'b1; // treat an active line after reset as mid-frame
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      mem_be_q      <= '0;
      stat_valid_q  <= 1'b0;
      stat_len_q    <= '0;
      stat_fcs_ok_q <= 1'b0;
      stat_err_q    <= 1'b0;
      stat_runt_q   <= 1'b0;
      drop_cnt_q    <= '0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      err_q         <= err_d;
      asm_q         <= asm_d;
      dv_prev_q     <= rx_dv_i;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      mem_be_q      <= mem_be_d;
      stat_valid_q  <= stat_valid_d;
      stat_len_q    <= stat_len_d;
      stat_fcs_ok_q <= stat_fcs_ok_d;
      stat_err_q    <= stat_err_d;
      stat_runt_q   <= stat_runt_d;
      drop_cnt_q    <= drop_cnt_d;
      busy_q        <= busy_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        // Only a line that was idle last cycle may start a preamble.
        if (rx_dv_i) begin
          state_d = (!dv_prev_q && (rxd_i == ETH_PREAMBLE)) ? ST_PREAMBLE : ST_DROP;
        end
      end
      ST_PREAMBLE: begin
        if (!rx_dv_i) begin
          state_d = ST_IDLE;
        end else if (rxd_i == ETH_SFD) begin
          state_d = stat_valid_q ? ST_DROP : ST_DATA;
        end else if (rxd_i != ETH_PREAMBLE) begin
          state_d = ST_DROP;
        end
      end
      ST_DATA, ST_DROP: begin
        if (!rx_dv_i) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath and output next values.
  always_comb begin
    cnt_d         = cnt_q;
    err_d         = err_q;
    asm_d         = asm_q;
    mem_we_d      = 1'b0;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    mem_be_d      = mem_be_q;
    stat_valid_d  = stat_valid_q;
    stat_len_d    = stat_len_q;
    stat_fcs_ok_d = stat_fcs_ok_q;
    stat_err_d    = stat_err_q;
    stat_runt_d   = stat_runt_q;
    drop_cnt_d    = drop_cnt_q;
    busy_d        = (state_d != ST_IDLE);
    crc_clr_c     = 1'b0;
    crc_en_c      = (state_q == ST_DATA) && rx_dv_i;

    if (stat_valid_q && stat_ready_i) begin
      stat_valid_d = 1'b0;
    end

    if (sfd_seen) begin
      if (stat_valid_q) begin
        if (drop_cnt_q != '1) begin
          drop_cnt_d = drop_cnt_q + LW'(1);
        end
      end else begin
        crc_clr_c = 1'b1;
        cnt_d     = '0;
        err_d     = 1'b0;
        asm_d     = '0;
      end
    end

    if (state_q == ST_DATA) begin
      if (rx_dv_i) begin
        if (cnt_q != '1) begin
          cnt_d = cnt_q + LW'(1);
        end
        if (rx_er_i || ovf) begin
          err_d = 1'b1;
        end
        if (!ovf) begin
          asm_d[{lane, 3'b000} +: 8] = rxd_i;
          if (lane == 3'd7) begin
            mem_we_d    = 1'b1;
            mem_addr_d  = cnt_q[BUF_AW+2:3];
            mem_wdata_d = asm_d;
            mem_be_d    = 8'hFF;
            asm_d       = '0;
          end
        end
      end else begin
        // End of frame: flush the partial word and publish the status.
        if (!ovf && (lane != 3'd0)) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = cnt_q[BUF_AW+2:3];
          mem_wdata_d = asm_q;
          mem_be_d    = ~(8'hFF << lane);
        end
        stat_valid_d  = 1'b1;
        stat_len_d    = cnt_q;
        stat_fcs_ok_d = (crc_val == CRC_RESIDUE);
        stat_err_d    = err_q;
        stat_runt_d   = (cnt_q < LW'(ETH_MIN_LEN));
      end
    end
  end

  assign mem_we_o      = mem_we_q;
  assign mem_addr_o    = mem_addr_q;
  assign mem_wdata_o   = mem_wdata_q;
  assign mem_be_o      = mem_be_q;
  assign stat_valid_o  = stat_valid_q;
  assign stat_len_o    = stat_len_q;
  assign stat_fcs_ok_o = stat_fcs_ok_q;
  assign stat_err_o    = stat_err_q;
  assign stat_runt_o   = stat_runt_q;
  assign drop_cnt_o    = drop_cnt_q;
  assign busy_o        = busy_q;

endmodule

// File: tb/tb_eth_rx_framer.sv
// tb_eth_rx_framer: directed bench for eth_rx_framer. Builds frames with a
// bench-side CRC, drives them on negedges and checks buffer writes and status.
module tb_eth_rx_framer;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        rx_dv_i;
  logic        rx_er_i;
  logic [7:0]  rxd_i;
  logic        mem_we_o;
  logic [7:0]  mem_addr_o;
  logic [63:0] mem_wdata_o;
  logic [7:0]  mem_be_o;
  logic        stat_valid_o;
  logic        stat_ready_i;
  logic [15:0] stat_len_o;
  logic        stat_fcs_ok_o;
  logic        stat_err_o;
  logic        stat_runt_o;
  logic [15:0] drop_cnt_o;
  logic        busy_o;

  int total = 0;
  int bad   = 0;

  logic [7:0]  frm [0:127];
  int          flen;
  logic [7:0]  wa  [0:63];
  logic [7:0]  wbe [0:63];
  logic [63:0] wd  [0:63];
  int          nw = 0;
  int          nw_at_rst = 0;

  always #5 clk = ~clk;

  eth_rx_framer dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .rx_dv_i       (rx_dv_i),
    .rx_er_i       (rx_er_i),
    .rxd_i         (rxd_i),
    .mem_we_o      (mem_we_o),
    .mem_addr_o    (mem_addr_o),
    .mem_wdata_o   (mem_wdata_o),
    .mem_be_o      (mem_be_o),
    .stat_valid_o  (stat_valid_o),
    .stat_ready_i  (stat_ready_i),
    .stat_len_o    (stat_len_o),
    .stat_fcs_ok_o (stat_fcs_ok_o),
    .stat_err_o    (stat_err_o),
    .stat_runt_o   (stat_runt_o),
    .drop_cnt_o    (drop_cnt_o),
    .busy_o        (busy_o)
  );

  // Log every buffer write for later inspection.
  always @(negedge clk) begin
    if (mem_we_o && nw < 64) begin
      wa[nw]  = mem_addr_o;
      wbe[nw] = mem_be_o;
      wd[nw]  = mem_wdata_o;
      nw      = nw + 1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Bit-serial reference CRC (LFSR form, data LSB first).
  function automatic logic [31:0] ref_crc(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    logic        fb;
    r = c;
    for (int b = 0; b < 8; b++) begin
      fb = r[0] ^ d[b];
      r  = {1'b0, r[31:1]};
      if (fb) r = r ^ 32'hEDB88320;
    end
    return r;
  endfunction

  // Payload of n bytes followed by its FCS, least significant byte first.
  task automatic build(input int n);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++) begin
      frm[i] = 8'((i * 7 + 3) & 255);
      c = ref_crc(c, frm[i]);
    end
    c = ~c;
    for (int j = 0; j < 4; j++) frm[n + j] = c[8*j +: 8];
    flen = n + 4;
  endtask

  function automatic logic [63:0] pack(input int base, input int nb);
    logic [63:0] w;
    w = '0;
    for (int j = 0; j < nb; j++) w[8*j +: 8] = frm[base + j];
    return w;
  endfunction

  task automatic drive(input logic [7:0] b, input logic er, input logic r);
    @(negedge clk);
    rx_dv_i = 1'b1;
    rxd_i   = b;
    rx_er_i = er;
    rst_i   = r;
  endtask

  task automatic drive_idle();
    @(negedge clk);
    rx_dv_i = 1'b0;
    rxd_i   = 8'h00;
    rx_er_i = 1'b0;
    rst_i   = 1'b0;
  endtask

  task automatic send_frame(input bit bad_pre, input int er_at, input int rst_at);
    for (int i = 0; i < 7; i++) drive((bad_pre && i == 1) ? 8'h5A : 8'h55, 1'b0, 1'b0);
    drive(8'hD5, 1'b0, 1'b0);
    for (int i = 0; i < flen; i++) begin
      drive(frm[i], 1'(i == er_at),
            1'((rst_at >= 0) && ((i == rst_at) || (i == rst_at + 1))));
      if (rst_at >= 0 && i == rst_at + 1) begin
        chk("rst_we",    64'(mem_we_o), 64'd0);
        chk("rst_addr",  64'(mem_addr_o), 64'd0);
        chk("rst_wdata", mem_wdata_o, 64'd0);
        chk("rst_be",    64'(mem_be_o), 64'd0);
        chk("rst_valid", 64'(stat_valid_o), 64'd0);
        chk("rst_len",   64'(stat_len_o), 64'd0);
        chk("rst_drop",  64'(drop_cnt_o), 64'd0);
        chk("rst_busy",  64'(busy_o), 64'd0);
        nw_at_rst = nw;
      end
    end
    drive_idle();
  endtask

  task automatic ack();
    stat_ready_i = 1'b1;
    @(negedge clk);
    stat_ready_i = 1'b0;
    chk("ack_valid_fall", 64'(stat_valid_o), 64'd0);
  endtask

  initial begin
    rst_i = 1'b1; rx_dv_i = 1'b0; rx_er_i = 1'b0; rxd_i = 8'h00; stat_ready_i = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_we",    64'(mem_we_o), 64'd0);
    chk("reset_wdata", mem_wdata_o, 64'd0);
    chk("reset_valid", 64'(stat_valid_o), 64'd0);
    chk("reset_busy",  64'(busy_o), 64'd0);
    chk("reset_drop",  64'(drop_cnt_o), 64'd0);
    rst_i = 1'b0;
    repeat (2) @(negedge clk);

    // Valid 64-byte frame.
    build(60); nw = 0;
    send_frame(1'b0, -1, -1);
    chk("v_last_we",   64'(mem_we_o), 64'd1);
    chk("v_last_addr", 64'(mem_addr_o), 64'd7);
    chk("v_pre_valid", 64'(stat_valid_o), 64'd0);
    @(negedge clk);
    chk("v_valid", 64'(stat_valid_o), 64'd1);
    chk("v_len",   64'(stat_len_o), 64'd64);
    chk("v_fcs",   64'(stat_fcs_ok_o), 64'd1);
    chk("v_err",   64'(stat_err_o), 64'd0);
    chk("v_runt",  64'(stat_runt_o), 64'd0);
    chk("v_no_flush", 64'(mem_we_o), 64'd0);
    chk("v_nw",    64'(nw), 64'd8);
    for (int i = 0; i < 8; i++) begin
      chk("v_addr", 64'(wa[i]), 64'(i));
      chk("v_be",   64'(wbe[i]), 64'hFF);
    end
    chk("v_word0", wd[0], pack(0, 8));
    chk("v_word7", wd[7], pack(56, 8));
    ack();

    // Same frame with byte 10 corrupted.
    build(60); frm[10] = frm[10] ^ 8'h01; nw = 0;
    send_frame(1'b0, -1, -1);
    @(negedge clk);
    chk("c_valid", 64'(stat_valid_o), 64'd1);
    chk("c_fcs",   64'(stat_fcs_ok_o), 64'd0);
    chk("c_len",   64'(stat_len_o), 64'd64);
    chk("c_nw",    64'(nw), 64'd8);
    ack();

    // Short 61-byte frame: partial flush on frame end.
    build(57); nw = 0;
    send_frame(1'b0, -1, -1);
    chk("s_pre_valid", 64'(stat_valid_o), 64'd0);
    @(negedge clk);
    chk("s_valid",  64'(stat_valid_o), 64'd1);
    chk("s_we",     64'(mem_we_o), 64'd1);
    chk("s_addr",   64'(mem_addr_o), 64'd7);
    chk("s_be",     64'(mem_be_o), 64'h1F);
    chk("s_wdata",  mem_wdata_o & 64'h000000FFFFFFFFFF, pack(56, 5));
    chk("s_len",    64'(stat_len_o), 64'd61);
    chk("s_runt",   64'(stat_runt_o), 64'd1);
    chk("s_fcs",    64'(stat_fcs_ok_o), 64'd1);
    ack();

    // Status pending: second frame dropped.
    build(60);
    send_frame(1'b0, -1, -1);
    @(negedge clk);
    chk("p_valid_a", 64'(stat_valid_o), 64'd1);
    build(57); nw = 0;
    send_frame(1'b0, -1, -1);
    @(negedge clk);
    chk("p_nw",     64'(nw), 64'd0);
    chk("p_drop",   64'(drop_cnt_o), 64'd1);
    chk("p_valid",  64'(stat_valid_o), 64'd1);
    chk("p_len",    64'(stat_len_o), 64'd64);
    ack();

    // Bad preamble: no writes, no status.
    build(60); nw = 0;
    send_frame(1'b1, -1, -1);
    @(negedge clk);
    chk("bp_nw",    64'(nw), 64'd0);
    chk("bp_valid", 64'(stat_valid_o), 64'd0);

    // rx_er pulse on byte 20.
    build(60);
    send_frame(1'b0, 20, -1);
    @(negedge clk);
    chk("er_valid", 64'(stat_valid_o), 64'd1);
    chk("er_err",   64'(stat_err_o), 64'd1);
    chk("er_len",   64'(stat_len_o), 64'd64);
    ack();

    // Reset mid-frame at byte 30, then a clean frame.
    build(60); nw = 0;
    send_frame(1'b0, -1, 30);
    @(negedge clk);
    chk("r_no_writes", 64'(nw), 64'(nw_at_rst));
    chk("r_valid",     64'(stat_valid_o), 64'd0);
    build(60); nw = 0;
    send_frame(1'b0, -1, -1);
    @(negedge clk);
    chk("r2_valid", 64'(stat_valid_o), 64'd1);
    chk("r2_len",   64'(stat_len_o), 64'd64);
    chk("r2_fcs",   64'(stat_fcs_ok_o), 64'd1);
    chk("r2_nw",    64'(nw), 64'd8);
    ack();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
